varredura_matriz_caixa: RTL and testbench
=========================================

Name: varredura_matriz_caixa

Overview:
- Scan driver for the 5-column x 7-row LED matrix that shows the tank level.
- Conditions the raw alto/medio/baixo sensors (2-FF sync plus debounce) and freezes them per frame so the image never tears.
- Drives a one-hot column index to the combinational row decoder, then registers and blanks the decoder's row outputs toward the matrix.

Parameters:
- DIV, 10000: clocks per column slot. Constraint: DIV >= 2.
- BLANK, 100: blanked clocks at the start of each slot. Constraint: 1 <= BLANK < DIV.
- DEBOUNCE, 50000: clocks a synced sensor must differ from its stable value before it is accepted. Constraint: DEBOUNCE >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alto_in, medio_in, baixo_in  in  1 each  raw, asynchronous level sensors
- l_in  in  7  row outputs l0..l6 from the row decoder (bit n = ln)
- alto, medio, baixo  out  1 each  frame-stable sensor levels, to the decoder
- col_dec  out  5  one-hot column index to the decoder; never blanked
- col  out  5  column drive to the matrix, active-high, blanked
- linhas  out  7  row drive to the matrix, active-high, blanked
- fim_quadro  out  1  one-clock pulse at each frame boundary

Behaviour:
- Reset: applies on clk edge when reset=1.
  - cnt=0, idx=0, col_dec=5'b00001, col=0, linhas=0, fim_quadro=0.
  - alto/medio/baixo=0; all sync FFs, stable values and debounce counters = 0.
  - Reset mid-scan aborts the slot; the first post-reset slot is column 0, starting with a full blank.
- Slot counter: cnt counts 0..DIV-1 each clock. At cnt==DIV-1 it returns to 0 and idx advances 0->1->2->3->4->0. col_dec = onehot(idx), registered.
- Outputs: let cnt', idx' be the next-state values at an edge.
  - col <= (cnt' >= BLANK) ? onehot(idx') : 0.
  - linhas <= (cnt' >= BLANK) ? l_in : 0. l_in is sampled while col_dec = onehot(idx).
  - Blank phase: col = 0 and linhas = 0 for exactly BLANK clocks per slot.
  - Lit phase: col and linhas lit for DIV-BLANK clocks per slot.
  - Because BLANK >= 1, a slot change is always blanked, so there is no ghosting.
- Frame boundary: the edge where idx goes 4->0.
  - fim_quadro <= 1 for that one cycle, 0 otherwise.
  - Same edge: alto/medio/baixo <= stable values. No other edge changes them.
  - Frame period = 5*DIV clocks.
- Debounce, per sensor, independently:
  - raw -> s1 -> s2 (2-FF synchronizer).
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE-1: stable <= s2, counter <= 0.
  - Else: counter <= counter + 1.
  - Any return of s2 to the stable value before acceptance clears the counter.
- Latency:
  - Raw change to stable = 2 + DEBOUNCE clocks.
  - Stable to alto/medio/baixo = up to 5*DIV clocks (next frame boundary).
- Simultaneous events: a stable update on the frame-boundary edge itself is not seen by that latch; it is taken at the following frame.
- Counter widths: clog2 of DIV and of DEBOUNCE; no overflow. Inconsistent sensor combinations (e.g. alto=1, medio=0) are passed unchanged; the decoder draws the error pattern.

Test Plan (DIV=8, BLANK=2, DEBOUNCE=3):
- Reset: hold reset 3 clocks -> col=0, linhas=0, col_dec=00001, fim_quadro=0, alto=medio=baixo=0.
- Scan sequence: free run -> col repeats 0,0 then 00001 for 6 clocks; then 0,0 then 00010 x6; ... through 10000. col_dec steps every 8 clocks. fim_quadro pulses once every 40 clocks, on the same cycle col_dec returns to 00001.
- Row blanking: l_in=7'h55 constant -> linhas=7'h55 exactly when col!=0, else 0. Change l_in to 7'h2A mid-slot -> linhas follows one clock later, only while lit.
- Glitch reject: pulse medio_in high for 2 clocks -> medio never changes. Hold medio_in high 5+ clocks -> medio goes 1 on the first fim_quadro edge after acceptance, not before.
- Frame freeze: change baixo_in at col_dec=00100 -> baixo stays constant until the next fim_quadro; no mid-frame change.
- Reset mid-scan: assert reset while col_dec=01000 is lit -> next cycle col=0, linhas=0. The scan restarts at col_dec=00001 with 2 blank clocks, and latched sensors are 0.

Source files
------------

// File: rtl/varredura_matriz_caixa.sv
// Scan driver for the 5x7 tank-level LED matrix.
// Ports: clk, reset (sync, active-high); alto_in/medio_in/baixo_in raw
// sensors; l_in row pattern from the decoder; alto/medio/baixo
// frame-stable levels; col_dec one-hot column to the decoder; col and
// linhas blanked matrix drive; fim_quadro one-clock frame pulse.
module varredura_matriz_caixa #(
    parameter int DIV      = 10000,
    parameter int BLANK    = 100,
    parameter int DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alto_in,
    input  logic       medio_in,
    input  logic       baixo_in,
    input  logic [6:0] l_in,
    output logic       alto,
    output logic       medio,
    output logic       baixo,
    output logic [4:0] col_dec,
    output logic [4:0] col,
    output logic [6:0] linhas,
    output logic       fim_quadro
);

    localparam int CW = $clog2(DIV);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [2:0]    IDX_LAST  = 3'd4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    col_dec_q, col_dec_d;
    logic [4:0]    col_q, col_d;
    logic [6:0]    linhas_q, linhas_d;
    logic          fim_q, fim_d;
    logic          lit;

    // Sensor vectors: bit 2 = alto, bit 1 = medio, bit 0 = baixo.
    logic [2:0]    raw;
    logic [2:0]    s1_q, s1_d;
    logic [2:0]    s2_q, s2_d;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    sens_q, sens_d;
    logic [DW-1:0] dbc_q [3];
    logic [DW-1:0] dbc_d [3];

    assign raw = {alto_in, medio_in, baixo_in};

    function automatic logic [4:0] onehot(input logic [2:0] i);
        return 5'b00001 << i;
    endfunction

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        fim_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                fim_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // Decisions use next-state values so the blank window lines up
        // exactly with the first BLANK clocks of every slot.
        lit       = (cnt_d >= CNT_BLANK);
        col_dec_d = onehot(idx_d);
        col_d     = lit ? col_dec_d : 5'b0;
        linhas_d  = lit ? l_in : 7'b0;

        // Latch the old stable values; an acceptance on this same edge
        // waits for the next frame.
        sens_d = fim_d ? stable_q : sens_q;

        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        dbc_d    = dbc_q;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_LAST) begin
                stable_d[i] = s2_q[i];
                dbc_d[i]    = '0;
            end else begin
                dbc_d[i] = dbc_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            col_dec_q <= 5'b00001;
            col_q     <= '0;
            linhas_q  <= '0;
            fim_q     <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            sens_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            col_dec_q <= col_dec_d;
            col_q     <= col_d;
            linhas_q  <= linhas_d;
            fim_q     <= fim_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            sens_q    <= sens_d;
            for (int i = 0; i < 3; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end

    assign col_dec    = col_dec_q;
    assign col        = col_q;
    assign linhas     = linhas_q;
    assign fim_quadro = fim_q;
    assign alto       = sens_q[2];
    assign medio      = sens_q[1];
    assign baixo      = sens_q[0];

endmodule

// File: tb/tb_varredura_matriz_caixa.sv
// Bench for varredura_matriz_caixa (DIV=8, BLANK=2, DEBOUNCE=3).
// Directed phases plus random rows/sensors against a frame-level model.
module tb_varredura_matriz_caixa;

    localparam int DIV = 8;
    localparam int BLANK = 2;
    localparam int DEB = 3;
    localparam int FRAME = 5 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sens_in = 3'b000;
    logic [6:0] l_in = 7'h55;
    logic       alto, medio, baixo;
    logic [4:0] col_dec, col;
    logic [6:0] linhas;
    logic       fim_quadro;

    varredura_matriz_caixa #(
        .DIV(DIV),
        .BLANK(BLANK),
        .DEBOUNCE(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alto_in(sens_in[2]),
        .medio_in(sens_in[1]),
        .baixo_in(sens_in[0]),
        .l_in(l_in),
        .alto(alto),
        .medio(medio),
        .baixo(baixo),
        .col_dec(col_dec),
        .col(col),
        .linhas(linhas),
        .fim_quadro(fim_quadro)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: n = edges since reset; raw sensor history per edge.
    int       n = 0;
    bit [2:0] hist [0:4095];
    bit [2:0] stab = '0;
    bit [2:0] lat = '0;
    logic [4:0] e_col, e_cdec;
    logic [6:0] e_lin;
    logic       e_fim;

    function automatic bit [2:0] rawv(input int k);
        return (k < 1) ? 3'b000 : hist[k];
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic tick(input bit rst);
        bit [2:0] r;
        bit       flip;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            n    = 0;
            stab = '0;
            lat  = '0;
        end else begin
            n++;
            hist[n] = sens_in;
            // Frame latch takes stable values from before this edge.
            if (n % FRAME == 0) lat = stab;
            // Accept when the synced value (raw two edges back) has
            // disagreed with the stable value on DEB consecutive edges.
            for (int s = 0; s < 3; s++) begin
                flip = 1'b1;
                for (int j = 2; j < 2 + DEB; j++) begin
                    r = rawv(n - j);
                    if (r[s] == stab[s]) flip = 1'b0;
                end
                if (flip) stab[s] = ~stab[s];
            end
        end
        e_fim  = (n > 0) && (n % FRAME == 0);
        e_cdec = 5'(1 << ((n / DIV) % 5));
        e_col  = (n % DIV >= BLANK) ? e_cdec : 5'b0;
        e_lin  = (n % DIV >= BLANK) ? l_in : 7'b0;
        #1;
        chk("col", 7'(col), 7'(e_col));
        chk("col_dec", 7'(col_dec), 7'(e_cdec));
        chk("linhas", linhas, e_lin);
        chk("fim_quadro", 7'(fim_quadro), 7'(e_fim));
        chk("alto", 7'(alto), 7'(lat[2]));
        chk("medio", 7'(medio), 7'(lat[1]));
        chk("baixo", 7'(baixo), 7'(lat[0]));
    endtask

    initial begin
        // Reset held three clocks.
        repeat (3) tick(1'b1);

        // Free-running scan with constant rows.
        repeat (45) tick(1'b0);

        // Row change in the middle of a lit slot.
        for (int g = 0; g < 16 && (n % DIV) != 4; g++) tick(1'b0);
        l_in = 7'h2A;
        repeat (20) tick(1'b0);

        // Two-clock glitch on medio must be rejected.
        sens_in[1] = 1'b1;
        repeat (2) tick(1'b0);
        sens_in[1] = 1'b0;
        repeat (50) tick(1'b0);

        // Long hold on medio is accepted, shown at next frame.
        sens_in[1] = 1'b1;
        repeat (60) tick(1'b0);

        // baixo changes while column 2 is on; must wait for frame edge.
        for (int g = 0; g < 2 * FRAME && ((n / DIV) % 5) != 2; g++)
            tick(1'b0);
        sens_in[0] = 1'b1;
        repeat (60) tick(1'b0);

        // Random rows and sensor activity.
        repeat (400) begin
            l_in = 7'($urandom);
            for (int s = 0; s < 3; s++)
                if ($urandom_range(5) == 0) sens_in[s] = ~sens_in[s];
            tick(1'b0);
        end

        // Reset while column 3 is lit.
        sens_in = 3'b111;
        repeat (50) tick(1'b0);
        for (int g = 0; g < 2 * FRAME &&
             !(((n / DIV) % 5) == 3 && (n % DIV) == 4); g++)
            tick(1'b0);
        tick(1'b1);
        repeat (60) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
